column_config_loader: RTL and testbench
=======================================

COLUMN_CONFIG_LOADER -- requirements
Module: column_config_loader

Interface
REQ-001 SHALL have parameter CONFIG_W, default 582, the logic-column configuration width in bits.
REQ-002 SHALL have parameter WORD_W, default 32, the configuration stream word width in bits.
REQ-003 SHALL have port clock, input, 1, the single clock; all logic is rising-edge.
REQ-004 SHALL have port nreset, input, 1, the reset: synchronous, active-low.
REQ-005 SHALL have port start, input, 1, a one-cycle request to begin a load.
REQ-006 SHALL have port cfg_data, input, WORD_W, the configuration word.
REQ-007 SHALL have port cfg_valid, input, 1, qualifying cfg_data.
REQ-008 SHALL have port cfg_ready, output, 1, the loader accepting a word.
REQ-009 SHALL have port config_out, output, CONFIG_W, the active configuration driven to the logic column.
REQ-010 SHALL have port column_nreset, output, 1, the active-low reset driven to the logic column.
REQ-011 SHALL have port busy, output, 1, high while a load is in progress.
REQ-012 SHALL have port done, output, 1, high while a committed configuration is valid.
REQ-013 SHALL have port error, output, 1, high after a rejected load.

Function
REQ-014 SHALL implement the states IDLE, LOAD, CHECK, COMMIT, DONE and ERROR; CHECK exists only per REQ-030.
REQ-015 SHALL take a transfer on a rising edge where cfg_valid and cfg_ready are both high; cfg_ready SHALL be high only in LOAD and CHECK.
REQ-016 SHALL set NW = ceil(CONFIG_W/WORD_W), which is 19 at the defaults.
REQ-017 SHALL write word k to shadow[WORD_W*k +: WORD_W]; bits at or above CONFIG_W SHALL be discarded (word 18 uses bits [5:0] only).
REQ-018 SHALL, on start in IDLE, DONE or ERROR, go to LOAD, clear the word counter, and clear done and error.
REQ-019 SHALL ignore start in LOAD, CHECK and COMMIT.
REQ-020 SHALL, on the transfer of word NW-1, go to COMMIT (or to CHECK per REQ-030).
REQ-021 SHALL, in COMMIT, load config_out from the shadow register at the cycle end and go to DONE; config_out SHALL change only at this edge.
REQ-022 SHALL hold config_out at its previous value during LOAD and CHECK, so a reload never presents a partial configuration.
REQ-023 SHALL drive column_nreset low in IDLE-after-reset, LOAD, CHECK, COMMIT and ERROR, and high only in DONE.
REQ-024 SHALL make column_nreset rise on the same edge that updates config_out.
REQ-025 SHALL drive busy high exactly in LOAD, CHECK and COMMIT.
REQ-026 SHALL place no timeout on cfg_valid gaps; the counter advances only on transfers.

Reset
REQ-027 SHALL, while nreset is low at a rising edge, set the state to IDLE, config_out to 0, the shadow and counter to 0, column_nreset to 0, and busy, done, error and cfg_ready to 0.
REQ-028 SHALL treat a reset during any load as an abort: no partial commit, and outputs per REQ-027 from the next cycle.

Configuration
REQ-029 SHALL use the macro COLUMN_CFG_CHECKSUM_EN.
REQ-030 SHALL, with the macro defined, enter CHECK after word NW-1 and accept one further word, the checksum.
REQ-031 SHALL, with the macro defined, commit only if the checksum equals the XOR of all NW words as received; otherwise it SHALL go to ERROR with config_out unchanged and error set to 1.
REQ-032 SHALL, with the macro undefined, remove CHECK and ERROR, never assert error, and go from LOAD directly to COMMIT.

Structure
REQ-033 SHALL place the state enum, CONFIG_W and WORD_W defaults, and the NW computation in the shared package kfpga_cfg_pkg.
REQ-034 SHALL be a single module with no sub-modules; the shadow register and word counter are inline.

Verification
REQ-035 SHALL cover reset: hold nreset low for 2 cycles -> config_out=0, column_nreset=0, done=0, busy=0, cfg_ready=0.
REQ-036 SHALL cover a back-to-back load (macro off): start, then 19 words of 0xFFFFFFFF with valid always high -> config_out = 582 ones, with done=1 and column_nreset=1 two edges after the last transfer.
REQ-037 SHALL cover a gapped load: words k=0..18 carrying value k, with valid low on alternate cycles -> config_out[31:0]=0, config_out[63:32]=1, config_out[581:576]=6'h12.
REQ-038 SHALL cover a bad checksum (macro on): 19 words of 0xA5A5A5A5 plus checksum 0 (expected 0xA5A5A5A5) -> error=1, config_out unchanged, column_nreset=0.
REQ-039 SHALL cover a mid-load reset: nreset low after 10 transfers -> IDLE, config_out=0; a following full load succeeds normally.
REQ-040 SHALL cover a reload from DONE: start -> column_nreset=0 and busy=1 next cycle, config_out holds the old value until the new commit edge.

Source files
------------

// File: rtl/kfpga_cfg_pkg.sv
// Shared definitions for the logic-column configuration loader:
// FSM state encoding, default widths and the stream word-count helper.
package kfpga_cfg_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_CHECK,
        ST_COMMIT,
        ST_DONE,
        ST_ERROR
    } state_t;

    localparam int CONFIG_W_DEFAULT = 582;
    localparam int WORD_W_DEFAULT   = 32;

    // Number of stream words needed to cover config_w bits (ceiling division).
    function automatic int calc_nw(input int config_w, input int word_w);
        return (config_w + word_w - 1) / word_w;
    endfunction

    localparam int NW_DEFAULT = calc_nw(CONFIG_W_DEFAULT, WORD_W_DEFAULT);

endpackage

// File: rtl/column_config_loader.sv
// Logic-column configuration loader. Collects NW stream words into a shadow
// register and commits them to config_out in a single edge, releasing the
// column reset on that same edge so the column never sees a partial image.
// Optional build macro COLUMN_CFG_CHECKSUM_EN: after the last data word one
// extra word is accepted and must equal the XOR of all data words, otherwise
// the load is rejected (ERROR) and the old configuration is kept.
module column_config_loader
    import kfpga_cfg_pkg::*;
#(
    parameter int CONFIG_W = CONFIG_W_DEFAULT,
    parameter int WORD_W   = WORD_W_DEFAULT
) (
    input  logic                clock,
    input  logic                nreset,
    input  logic                start,
    input  logic [WORD_W-1:0]   cfg_data,
    input  logic                cfg_valid,
    output logic                cfg_ready,
    output logic [CONFIG_W-1:0] config_out,
    output logic                column_nreset,
    output logic                busy,
    output logic                done,
    output logic                error
);

    localparam int NW    = calc_nw(CONFIG_W, WORD_W);
    localparam int CNT_W = (NW > 1) ? $clog2(NW) : 1;
    localparam int IDX_W = (CONFIG_W > 1) ? $clog2(CONFIG_W) : 1;
    localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(NW - 1);

    state_t              state;
    state_t              state_nxt;
    logic [CNT_W-1:0]    word_cnt;
    logic [CONFIG_W-1:0] shadow;
    logic [CONFIG_W-1:0] shadow_nxt;
    logic                xfer;
    logic                load_start;
    logic                data_xfer;
`ifdef COLUMN_CFG_CHECKSUM_EN
    logic [WORD_W-1:0]   csum;
`endif

    assign cfg_ready     = (state == ST_LOAD) || (state == ST_CHECK);
    assign xfer          = cfg_valid && cfg_ready;
    assign data_xfer     = xfer && (state == ST_LOAD);
    assign load_start    = (state != ST_LOAD) && (state_nxt == ST_LOAD);
    assign busy          = (state == ST_LOAD) || (state == ST_CHECK) || (state == ST_COMMIT);
    assign done          = (state == ST_DONE);
    // The column leaves reset exactly when the committed image is presented.
    assign column_nreset = (state == ST_DONE);
`ifdef COLUMN_CFG_CHECKSUM_EN
    assign error         = (state == ST_ERROR);
`else
    assign error         = 1'b0;
`endif

    // State register.
    always_ff @(posedge clock) begin
        if (!nreset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; start is only honoured outside an active load.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE, ST_DONE: begin
                if (start) state_nxt = ST_LOAD;
            end
            ST_LOAD: begin
                if (xfer && (word_cnt == LAST_WORD)) begin
`ifdef COLUMN_CFG_CHECKSUM_EN
                    state_nxt = ST_CHECK;
`else
                    state_nxt = ST_COMMIT;
`endif
                end
            end
`ifdef COLUMN_CFG_CHECKSUM_EN
            ST_CHECK: begin
                if (xfer) state_nxt = (cfg_data == csum) ? ST_COMMIT : ST_ERROR;
            end
            ST_ERROR: begin
                if (start) state_nxt = ST_LOAD;
            end
`endif
            ST_COMMIT: begin
                state_nxt = ST_DONE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Merge the incoming word into the shadow image; bits past CONFIG_W are dropped.
    always_comb begin
        shadow_nxt = shadow;
        if (data_xfer) begin
            for (int i = 0; i < WORD_W; i++) begin
                if ((int'(word_cnt) * WORD_W + i) < CONFIG_W) begin
                    shadow_nxt[IDX_W'(int'(word_cnt) * WORD_W + i)] = cfg_data[i];
                end
            end
        end
    end

    // Shadow register and word counter; the counter moves only on data transfers.
    always_ff @(posedge clock) begin
        if (!nreset) begin
            shadow   <= '0;
            word_cnt <= '0;
        end else begin
            shadow <= shadow_nxt;
            if (load_start) begin
                word_cnt <= '0;
            end else if (data_xfer) begin
                word_cnt <= word_cnt + 1'b1;
            end
        end
    end

`ifdef COLUMN_CFG_CHECKSUM_EN
    // Running XOR of the data words, compared against the trailing checksum word.
    always_ff @(posedge clock) begin
        if (!nreset) begin
            csum <= '0;
        end else if (load_start) begin
            csum <= '0;
        end else if (data_xfer) begin
            csum <= csum ^ cfg_data;
        end
    end
`endif

    // Active configuration changes only on the commit edge.
    always_ff @(posedge clock) begin
        if (!nreset) begin
            config_out <= '0;
        end else if (state == ST_COMMIT) begin
            config_out <= shadow;
        end
    end

endmodule

// File: tb/tb_column_config_loader.sv
// Scoreboard bench for column_config_loader: stimulus pushes the expected
// committed image (or rejection) into a queue; a monitor pops and compares
// whenever done or error rises. Honours COLUMN_CFG_CHECKSUM_EN.
module tb_column_config_loader;
    import kfpga_cfg_pkg::*;

    localparam int CW = CONFIG_W_DEFAULT;
    localparam int WW = WORD_W_DEFAULT;
    localparam int NW = NW_DEFAULT;
    localparam int PW = NW * WW;

    logic          clock = 1'b0;
    logic          nreset;
    logic          start;
    logic [WW-1:0] cfg_data;
    logic          cfg_valid;
    logic          cfg_ready;
    logic [CW-1:0] config_out;
    logic          column_nreset;
    logic          busy;
    logic          done;
    logic          error;

    always #5 clock = ~clock;

    column_config_loader #(.CONFIG_W(CW), .WORD_W(WW)) dut (
        .clock         (clock),
        .nreset        (nreset),
        .start         (start),
        .cfg_data      (cfg_data),
        .cfg_valid     (cfg_valid),
        .cfg_ready     (cfg_ready),
        .config_out    (config_out),
        .column_nreset (column_nreset),
        .busy          (busy),
        .done          (done),
        .error         (error)
    );

    typedef struct packed {
        logic          is_err;
        logic [CW-1:0] cfg;
    } exp_t;

    exp_t          exp_q[$];
    int            n_vec = 0;
    int            n_err = 0;
    logic [WW-1:0] pat [NW];
    logic [CW-1:0] last_cfg;
    logic [CW-1:0] new_cfg;
    logic          done_q = 1'b0;
    logic          error_q = 1'b0;

    task automatic check_bit(input string name, input logic act, input logic req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0b, want %0b", name, act, req);
        end
    endtask

    task automatic check_vec(input string name, input logic [CW-1:0] act, input logic [CW-1:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h, want %h", name, act, req);
        end
    endtask

    // Monitor: compare at every rising done/error against the oldest expectation.
    always @(negedge clock) begin
        if ((done === 1'b1 && done_q !== 1'b1) || (error === 1'b1 && error_q !== 1'b1)) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_result: done=%0b error=%0b, want no result", done, error);
            end else begin
                check_bit("mon_error", error, exp_q[0].is_err);
                check_bit("mon_column_nreset", column_nreset, !exp_q[0].is_err);
                check_vec("mon_config_out", config_out, exp_q[0].cfg);
                void'(exp_q.pop_front());
            end
        end
        done_q  <= done;
        error_q <= error;
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Present one word and hold it until the loader has taken it.
    task automatic send_word(input logic [WW-1:0] w);
        int t;
        t = 0;
        cfg_data  = w;
        cfg_valid = 1'b1;
        @(negedge clock);
        while (cfg_ready !== 1'b1 && t < 50) begin
            @(negedge clock);
            t++;
        end
        if (cfg_ready !== 1'b1) begin
            n_vec++;
            n_err++;
            $display("FAIL xfer_timeout: cfg_ready=%0b, want 1", cfg_ready);
        end
        tick();
        cfg_valid = 1'b0;
    endtask

    // Start a load of pat[], queue its expected image, and stream the words.
    task automatic run_load(input bit gapped, input bit poke_start, input bit check_reload);
        logic [PW-1:0] pad;
        logic [WW-1:0] x;
        exp_t          e;
        pad = '0;
        x   = '0;
        for (int k = 0; k < NW; k++) begin
            pad[k*WW +: WW] = pat[k];
            x = x ^ pat[k];
        end
        new_cfg  = pad[CW-1:0];
        e.is_err = 1'b0;
        e.cfg    = new_cfg;
        exp_q.push_back(e);
        do_start();
        if (check_reload) begin
            check_bit("reload_column_nreset", column_nreset, 1'b0);
            check_bit("reload_busy", busy, 1'b1);
            check_bit("reload_error", error, 1'b0);
            check_vec("reload_hold_start", config_out, last_cfg);
        end
        for (int k = 0; k < NW; k++) begin
            send_word(pat[k]);
            if (check_reload && k == 10) check_vec("reload_hold_mid", config_out, last_cfg);
            if (gapped) begin
                if (poke_start && k == 5) start = 1'b1;
                tick();
                start = 1'b0;
            end
        end
`ifdef COLUMN_CFG_CHECKSUM_EN
        send_word(x);
`endif
    endtask

    task automatic wait_result();
        int t;
        t = 0;
        while (!(done === 1'b1 || error === 1'b1) && t < 20) begin
            tick();
            t++;
        end
        if (!(done === 1'b1 || error === 1'b1)) begin
            n_vec++;
            n_err++;
            $display("FAIL result_timeout: done=%0b error=%0b, want one high", done, error);
        end
        tick();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time exceeded, want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        nreset    = 1'b0;
        start     = 1'b0;
        cfg_valid = 1'b0;
        cfg_data  = '0;
        last_cfg  = '0;
        new_cfg   = '0;

        // Reset held for two edges.
        tick();
        tick();
        check_vec("rst_config_out", config_out, '0);
        check_bit("rst_column_nreset", column_nreset, 1'b0);
        check_bit("rst_done", done, 1'b0);
        check_bit("rst_busy", busy, 1'b0);
        check_bit("rst_cfg_ready", cfg_ready, 1'b0);
        check_bit("rst_error", error, 1'b0);
        nreset = 1'b1;
        tick();

        // Back-to-back load of all ones.
        for (int k = 0; k < NW; k++) pat[k] = 32'hFFFF_FFFF;
        run_load(1'b0, 1'b0, 1'b0);
        check_bit("b2b_commit_busy", busy, 1'b1);
        check_bit("b2b_commit_done", done, 1'b0);
        check_vec("b2b_commit_hold", config_out, '0);
        tick();
        check_bit("b2b_done", done, 1'b1);
        check_bit("b2b_column_nreset", column_nreset, 1'b1);
        check_bit("b2b_busy", busy, 1'b0);
        check_vec("b2b_config_out", config_out, {CW{1'b1}});
        tick();
        last_cfg = new_cfg;

        // Gapped reload from DONE, words carry their index, stray start mid-load.
        for (int k = 0; k < NW; k++) pat[k] = WW'(k);
        run_load(1'b1, 1'b1, 1'b1);
        wait_result();
        check_vec("gap_low_word", {{(CW-32){1'b0}}, config_out[31:0]}, {{(CW-32){1'b0}}, 32'h0});
        check_vec("gap_word1", {{(CW-32){1'b0}}, config_out[63:32]}, {{(CW-32){1'b0}}, 32'h1});
        check_vec("gap_top_bits", {{(CW-6){1'b0}}, config_out[581:576]}, {{(CW-6){1'b0}}, 6'h12});
        check_bit("gap_error", error, 1'b0);
        last_cfg = new_cfg;

        // Reset after ten transfers aborts the load.
        do_start();
        for (int k = 0; k < 10; k++) send_word(32'hC0DE_0000 | WW'(k));
        nreset = 1'b0;
        tick();
        check_vec("abort_config_out", config_out, '0);
        check_bit("abort_busy", busy, 1'b0);
        check_bit("abort_cfg_ready", cfg_ready, 1'b0);
        check_bit("abort_column_nreset", column_nreset, 1'b0);
        check_bit("abort_done", done, 1'b0);
        nreset = 1'b1;
        tick();
        for (int k = 0; k < NW; k++) pat[k] = 32'hC0DE_0000 | WW'(k);
        run_load(1'b0, 1'b0, 1'b0);
        wait_result();
        check_bit("post_abort_done", done, 1'b1);
        last_cfg = new_cfg;

`ifdef COLUMN_CFG_CHECKSUM_EN
        // Bad checksum: XOR of nineteen A5A5A5A5 words is A5A5A5A5, zero is sent.
        begin
            exp_t e;
            e.is_err = 1'b1;
            e.cfg    = last_cfg;
            exp_q.push_back(e);
        end
        do_start();
        for (int k = 0; k < NW; k++) send_word(32'hA5A5_A5A5);
        send_word(32'h0000_0000);
        wait_result();
        check_bit("badsum_error", error, 1'b1);
        check_bit("badsum_column_nreset", column_nreset, 1'b0);
        check_vec("badsum_config_out", config_out, last_cfg);
        // Recovery from ERROR with a good load.
        for (int k = 0; k < NW; k++) pat[k] = 32'h1234_5678 ^ WW'(k);
        run_load(1'b0, 1'b0, 1'b1);
        wait_result();
        last_cfg = new_cfg;
`endif

        tick();
        tick();
        n_vec++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL pending_results: %0d left, want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
